// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - shared state type and sizing helpers for the credit link receiver
package credit_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } credit_rx_state_t;

  localparam int CREDIT_WIDTH = 16;
  localparam int CREDIT_DEPTH = 4;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/credit_rx_fifo.sv
// rtl/credit_rx_fifo.sv - circular buffer with push/pop qualification for the link receiver
// CREDIT_LINK_RX_OVF_CHECK_EN adds the drop_o overflow-event output.
module credit_rx_fifo
  import credit_pkg::*;
#(
  parameter int WIDTH = CREDIT_WIDTH,
  parameter int DEPTH = CREDIT_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ack_i,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pop_o
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  ,
  output logic             drop_o
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && ack_i;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_push  = push_i && (!w_full || w_pop);

  assign req_o  = !w_empty;
  assign data_o = w_empty ? '0 : r_mem[r_rptr];
  assign pop_o  = w_pop;
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  assign drop_o = push_i && w_full && !w_pop;
`endif

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/credit_link_rx.sv
// rtl/credit_link_rx.sv - credit-based link receiver: buffers words, returns one credit per drain
// CREDIT_LINK_RX_OVF_CHECK_EN adds the sticky ovf_o port.
module credit_link_rx
  import credit_pkg::*;
#(
  parameter int WIDTH = CREDIT_WIDTH,
  parameter int DEPTH = CREDIT_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             link_valid_i,
  input  logic [WIDTH-1:0] link_data_bi,
  output logic             link_credit_o,
  output logic             ext_dataout_genfifo_req_o,
  output logic [WIDTH-1:0] ext_dataout_genfifo_wdata_bo,
  input  logic             ext_dataout_genfifo_ack_i
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] INIT_LAST = PW'(DEPTH - 1);

  credit_rx_state_t r_state;
  credit_rx_state_t w_state_nxt;
  logic [PW-1:0]    r_init_cnt;
  logic [PW-1:0]    w_init_nxt;
  logic [CW-1:0]    r_pend;
  logic [CW-1:0]    w_pend_nxt;
  logic             r_credit;
  logic             w_credit_nxt;
  logic             w_pop;
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  logic             w_drop;
  logic             r_ovf;
`endif

  credit_rx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (link_valid_i),
    .data_i (link_data_bi),
    .ack_i  (ext_dataout_genfifo_ack_i),
    .req_o  (ext_dataout_genfifo_req_o),
    .data_o (ext_dataout_genfifo_wdata_bo),
    .pop_o  (w_pop)
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    ,
    .drop_o (w_drop)
`endif
  );

  // Pops seen while INIT is still advertising are owed and paid out once in RUN.
  always_comb begin
    w_state_nxt  = r_state;
    w_init_nxt   = r_init_cnt;
    w_pend_nxt   = r_pend;
    w_credit_nxt = 1'b0;
    case (r_state)
      INIT: begin
        w_credit_nxt = 1'b1;
        w_init_nxt   = r_init_cnt + 1'b1;
        if (w_pop) begin
          w_pend_nxt = r_pend + 1'b1;
        end
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_credit_nxt = w_pop || (r_pend != '0);
        if (!w_pop && (r_pend != '0)) begin
          w_pend_nxt = r_pend - 1'b1;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_pend     <= '0;
      r_credit   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_nxt;
      r_pend     <= w_pend_nxt;
      r_credit   <= w_credit_nxt;
    end
  end

  assign link_credit_o = r_credit;

`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_credit_link_rx.sv
// tb/tb_credit_link_rx.sv - directed and soak checks for credit_link_rx
module tb_credit_link_rx;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             link_valid = 1'b0;
  logic [WIDTH-1:0] link_data = '0;
  logic             ack = 1'b0;
  logic             credit;
  logic             req;
  logic [WIDTH-1:0] wdata;
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int sc, occ, sent, popped;
  bit got_credit, do_pop, did_push;
  logic [WIDTH-1:0] exp_q [4] = '{16'h0021, 16'h0022, 16'h0023, 16'h0055};

  always #5 clk = ~clk;

  credit_link_rx #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i                        (clk),
    .rst_i                        (rst),
    .link_valid_i                 (link_valid),
    .link_data_bi                 (link_data),
    .link_credit_o                (credit),
    .ext_dataout_genfifo_req_o    (req),
    .ext_dataout_genfifo_wdata_bo (wdata),
    .ext_dataout_genfifo_ack_i    (ack)
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    ,
    .ovf_o                        (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    link_valid = 1'b1;
    link_data  = d;
    step();
    link_valid = 1'b0;
  endtask

  task automatic expect_init(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check({tag, "_credit"}, credit, 1);
      check({tag, "_req"}, req, 0);
    end
    step();
    check({tag, "_done"}, credit, 0);
  endtask

  initial begin
    rst = 1'b0;
    step();
    check("rst_credit", credit, 0);
    check("rst_req", req, 0);
    check("rst_wdata", wdata, 0);
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b1;
    expect_init("init");

    // streaming with ack held high
    ack = 1'b1; link_valid = 1'b1; link_data = 16'd1;
    step();
    check("s1_req", req, 1); check("s1_wdata", wdata, 1); check("s1_credit", credit, 0);
    link_data = 16'd2;
    step();
    check("s2_wdata", wdata, 2); check("s2_credit", credit, 1);
    link_data = 16'd3;
    step();
    check("s3_wdata", wdata, 3); check("s3_credit", credit, 1);
    link_valid = 1'b0;
    step();
    check("s4_req", req, 0); check("s4_credit", credit, 1);
    ack = 1'b0;
    step();
    check("s5_credit", credit, 0);

    // fill, hold, then drain in order
    for (int i = 0; i < 4; i++) begin
      push_word(16'h0010 + 16'(i));
      check("fill_req", req, 1); check("fill_head", wdata, 16'h0010);
    end
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_req", req, 1); check("drain_head", wdata, 16'h0010 + 16'(i));
      step();
      check("drain_credit", credit, 1);
    end
    check("drain_empty", req, 0);
    ack = 1'b0;
    step();
    check("drain_credit_end", credit, 0);

    // full with simultaneous push and pop, then overflow
    for (int i = 0; i < 4; i++) push_word(16'h0020 + 16'(i));
    link_valid = 1'b1; link_data = 16'h0055; ack = 1'b1;
    step();
    link_valid = 1'b0; ack = 1'b0;
    check("fullpp_credit", credit, 1); check("fullpp_req", req, 1); check("fullpp_head", wdata, 16'h0021);
    step();
    check("fullpp_credit_end", credit, 0);
    push_word(16'h00AA);
    check("ovf_credit", credit, 0); check("ovf_head", wdata, 16'h0021);
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    check("ovf_set", ovf, 1);
    step();
    check("ovf_sticky", ovf, 1);
`endif
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_req", req, 1); check("ovf_drain_head", wdata, 32'(exp_q[i]));
      step();
    end
    check("ovf_drain_empty", req, 0);
    ack = 1'b0;
    step();

    // reset with words buffered and a credit in flight
    for (int i = 0; i < 3; i++) push_word(16'h0031 + 16'(i));
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("mid_credit", credit, 1); check("mid_req", req, 1);
    rst = 1'b0;
    step();
    check("mid_rst_req", req, 0); check("mid_rst_credit", credit, 0); check("mid_rst_wdata", wdata, 0);
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    check("mid_rst_ovf", ovf, 0);
`endif
    rst = 1'b1;
    expect_init("reinit");

    // soak: credit-limited sender, 10% ack
    rst = 1'b0;
    step();
    rst = 1'b1;
    sc = 0; occ = 0; sent = 0; popped = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      got_credit = credit;
      did_push = (sc > 0);
      link_valid = did_push;
      if (did_push) begin
        link_data = 16'((sent % 400) + 1);
        sc--;
        sent++;
      end
      ack = ($urandom_range(0, 9) == 0);
      check("soak_req", req, (occ != 0));
      do_pop = req && ack;
      if (do_pop) begin
        check("soak_data", wdata, (popped % 400) + 1);
        popped++;
      end
      step();
      occ = occ + (did_push ? 1 : 0) - (do_pop ? 1 : 0);
      if (got_credit) sc++;
      check("soak_inv", (sc + occ <= DEPTH), 1);
    end
    link_valid = 1'b0;
    ack = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      got_credit = credit;
      do_pop = req && ack;
      if (do_pop) begin
        check("soak_tail_data", wdata, (popped % 400) + 1);
        popped++;
      end
      step();
      occ = occ - (do_pop ? 1 : 0);
      if (got_credit) sc++;
    end
    ack = 1'b0;
    check("soak_credits", sc, DEPTH);
    check("soak_occ", occ, 0);
    check("soak_req_end", req, 0);
    check("soak_progress", (popped > 100), 1);
`ifdef CREDIT_LINK_RX_OVF_CHECK_EN
    check("soak_ovf", ovf, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/credit_link_rx.md
# credit_link_rx

Receiving end of a credit-based link for 16-bit data streams, the counterpart to the credit-issuing sender stage of the credit pipeline. Accepts words from the link without backpressure and buffers them in a DEPTH-entry FIFO. Presents them downstream on a genfifo req/ack write interface and returns one credit pulse to the sender per word drained. After reset it advertises its full buffer capacity by emitting DEPTH initial credits.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 4, buffer entries and total credits advertised; power of two, ≥ 2
- clk_i  input  1  clock, all logic on posedge
- rst_i  input  1  reset, synchronous, active-low
- link_valid_i  input  1  sender pushes a word this cycle; never qualified by a ready
- link_data_bi  input  WIDTH  word carried with link_valid_i
- link_credit_o  output  1  one-cycle pulse returning one credit to the sender
- ext_dataout_genfifo_req_o  output  1  buffer holds a word for downstream
- ext_dataout_genfifo_wdata_bo  output  WIDTH  head word
- ext_dataout_genfifo_ack_i  input  1  downstream consumes the head word when sampled with req high
- ovf_o  output  1  sticky overflow flag; present only with the configuration macro

## Operation
- FSM states are INIT and RUN. Reset (rst_i low at a posedge) forces INIT, clears the credit-issue counter, and sets the FIFO to empty.
- INIT:
  - link_credit_o is high for exactly DEPTH consecutive cycles, beginning the first cycle after rst_i is sampled high.
  - After the DEPTH-th pulse the FSM moves to RUN.
- RUN: link_credit_o is a registered pulse, high in the cycle after each pop.
- Push:
  - A word is written when link_valid_i is high, in both INIT and RUN.
  - The write is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Pop: occurs when req_o and ack_i are both high; the read pointer advances.
- Occupancy counter width is $clog2(DEPTH)+1.
  - Push only: +1. Pop only: −1. Both, or neither: unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Overflow is a push while full with no same-cycle pop. The word is dropped; FIFO contents and pointers are unchanged.
- Invariant: credits outstanding at the sender plus occupancy plus pending credit pulses equals DEPTH.

## Timing
- Reset values of outputs: link_credit_o=0, req_o=0, wdata_bo=0, ovf_o=0.
- Link to downstream latency is 1 cycle. A word pushed at edge N gives req_o high and wdata_bo equal to that word after edge N.
- req_o = !empty. wdata_bo is driven from the head entry and is stable while req_o is high and ack_i is low.
- Pop to credit latency is 1 cycle. A pop at edge N makes link_credit_o high for the cycle after edge N.
- Back-to-back pops produce back-to-back credit pulses; none are merged or lost.
- Push into an empty FIFO with ack_i high in the same cycle is not a pop, because req_o was low.
- Reset mid-operation:
  - Buffered words are discarded.
  - Pending credit pulses are cancelled.
  - The INIT sequence restarts.

## Configuration
- CREDIT_LINK_RX_OVF_CHECK_EN
  - Defined: ovf_o port exists. ovf_o sets the cycle after the first overflow and holds until reset.
  - Undefined: ovf_o port is absent. Overflow words are still dropped, with no indication.

## Structure
- Shared package credit_pkg:
  - state enum credit_rx_state_t with values INIT and RUN
  - default WIDTH and DEPTH constants
  - localparam helpers for pointer width and counter width
- Sub-module credit_rx_fifo holds the circular buffer, pointers, occupancy counter, full/empty flags, and push/pop qualification. The top level holds the FSM, credit generation, and the ovf flag.

## Test plan
- Release reset at cycle 0 with link idle:
  - Expect link_credit_o high in cycles 1–4 and low afterwards.
  - Expect req_o=0 throughout.
- Push values 1, 2, 3 on consecutive cycles with ack_i held high:
  - Expect wdata_bo = 1, 2, 3 on the cycles after each push.
  - Expect three credit pulses, each one cycle after its pop.
- Push 4 words with ack_i low:
  - Expect full; wdata_bo=first word while req_o stays high.
  - Then raise ack_i; expect pops in order with 4 credit pulses.
- With the FIFO full, push 0x55 and ack in the same cycle: expect 0x55 accepted, occupancy stays 4, one credit pulse.
- With the FIFO full, push 0xAA and no ack (macro defined):
  - Expect 0xAA dropped and ovf_o=1 the next cycle, sticky.
  - Repeat the run without the macro: contents are unchanged.
- Pull rst_i low for one edge with 2 words buffered and a credit pending: expect req_o=0 next cycle, no credit pulse, then a fresh 4-pulse INIT sequence.
- Soak run:
  - Sender model starts with 0 credits and sends a ramp of values 1..400 wrapping, whenever it holds credits.
  - Downstream ack is random, high 10% of cycles.
  - Run 4000 cycles. Expect in-order data, no overflow, and the credit invariant to hold every cycle.
